// File: rtl/ram_pkg.sv
// Shared constants and word types for the scratch RAM.
// Defaults give a 16 x 8 array.
package ram_pkg;

    localparam int RAM_DATA_W_DEF = 8;
    localparam int RAM_ADDR_W_DEF = 4;

    typedef logic [RAM_ADDR_W_DEF-1:0] ram_addr_t;
    typedef logic [RAM_DATA_W_DEF-1:0] ram_data_t;

endpackage

// File: rtl/ram_valid_tracker.sv
// Per-word written-since-reset bitmap and registered rd_uninit flag.
// Used by ram only when RAM_UNINIT_CHK_EN is defined.
module ram_valid_tracker
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    output logic              rd_uninit
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] valid;

    // Mark a word valid on write; clear the whole map on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (we) begin
            valid[addr] <= 1'b1;
        end
    end

    // Flag reads of never-written words; a write cycle reads new data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_uninit <= 1'b0;
        end else if (we) begin
            rd_uninit <= 1'b0;
        end else begin
            rd_uninit <= !valid[addr];
        end
    end

endmodule

// File: rtl/ram.sv
// Single-port flop-based RAM, registered write-first read port.
// Optional macro RAM_UNINIT_CHK_EN adds the rd_uninit tracker.
module ram
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W_DEF,
    parameter int ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              rd_uninit
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: reset clears every word and beats any pending write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= din;
        end
    end

    // Read port: every cycle, new data forwarded on a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (we) begin
            dout <= din;
        end else begin
            dout <= mem[addr];
        end
    end

`ifdef RAM_UNINIT_CHK_EN
    ram_valid_tracker #(
        .ADDR_W (ADDR_W)
    ) u_valid (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .addr      (addr),
        .rd_uninit (rd_uninit)
    );
`else
    assign rd_uninit = 1'b0;
`endif

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for ram.
// Expected rd_uninit follows RAM_UNINIT_CHK_EN.
module tb_ram;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rd_uninit;

    int total = 0;
    int bad   = 0;

`ifdef RAM_UNINIT_CHK_EN
    localparam logic UNINIT = 1'b1;
`else
    localparam logic UNINIT = 1'b0;
`endif

    ram #(
        .DATA_W (8),
        .ADDR_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .rd_uninit (rd_uninit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs at negedge, clock once, settle 1 time unit past posedge.
    task automatic cyc(input logic r, input logic w,
                       input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        rst_n = r;
        we    = w;
        addr  = a;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d,
                      input string tag);
        cyc(1'b1, 1'b1, a, d);
        check({tag, "_dout"}, dout, d);
        check({tag, "_uninit"}, {7'b0, rd_uninit}, 8'h00);
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e,
                      input logic u, input string tag);
        cyc(1'b1, 1'b0, a, 8'h00);
        check({tag, "_dout"}, dout, e);
        check({tag, "_uninit"}, {7'b0, rd_uninit}, {7'b0, u});
    endtask

    initial begin
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = '0;
        din   = '0;

        cyc(1'b0, 1'b1, 4'h3, 8'hEE);
        cyc(1'b0, 1'b0, 4'h0, 8'h00);
        check("rst_dout", dout, 8'h00);
        check("rst_uninit", {7'b0, rd_uninit}, 8'h00);

        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 8'h00, UNINIT, $sformatf("rst_rd%0d", i));
        end

        wr(4'h1, 8'hA5, "wr1");
        wr(4'h2, 8'h3C, "wr2");
        wr(4'h3, 8'hFF, "wr3");
        rd(4'h1, 8'hA5, 1'b0, "rb1");
        rd(4'h2, 8'h3C, 1'b0, "rb2");
        rd(4'h3, 8'hFF, 1'b0, "rb3");

        wr(4'h5, 8'h11, "col_pre");
        rd(4'h5, 8'h11, 1'b0, "col_old");
        wr(4'h5, 8'h77, "col_wr");
        rd(4'h5, 8'h77, 1'b0, "col_rd");

        wr(4'h0, 8'h01, "ow0");
        wr(4'hF, 8'h80, "owF1");
        wr(4'hF, 8'hC3, "owF2");
        rd(4'h0, 8'h01, 1'b0, "bd0");
        rd(4'hF, 8'hC3, 1'b0, "bdF");

        cyc(1'b0, 1'b1, 4'h2, 8'h5A);
        check("mid_rst_dout", dout, 8'h00);
        check("mid_rst_uninit", {7'b0, rd_uninit}, 8'h00);
        rd(4'h2, 8'h00, UNINIT, "mid_rd2");
        rd(4'hF, 8'h00, UNINIT, "mid_rdF");
        rd(4'h5, 8'h00, UNINIT, "mid_rd5");

        wr(4'h4, 8'h9C, "un_wr4");
        rd(4'h4, 8'h9C, 1'b0, "un_rd4");
        rd(4'h6, 8'h00, UNINIT, "un_rd6");
        rd(4'h4, 8'h9C, 1'b0, "un_rd4b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
